lane_byte_arbiter: RTL and testbench
====================================

Name: lane_byte_arbiter

Overview:
Round-robin scheduler that shares one byte-wide output channel among NUM_LANES serial byte receivers (one per Ethernet wire). Watches each lane's data_ready and grants one lane at a time. Captures that lane's byte and error flags, then returns the data_read handshake to the receiver. Presents the byte, its lane index and error flags on a valid/ready stream to the downstream packet parser.

Parameters:
NUM_LANES, 8, number of receiver lanes arbitrated (2..8, power of two)
LANE_W, 3, width of the lane index; must equal log2(NUM_LANES)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  system clock, all logic rising-edge
n_rst  input  1  asynchronous active-low reset
lane_enable  input  NUM_LANES  per-lane enable mask; 0 = lane never granted
lane_data_ready  input  NUM_LANES  receiver byte-available flags
lane_rx_data  input  NUM_LANES*8  receiver bytes, lane i at bits [8i+7:8i]
lane_overrun  input  NUM_LANES  receiver overrun flags
lane_framing_error  input  NUM_LANES  receiver framing-error flags
lane_data_read  output  NUM_LANES  one-cycle byte-consumed pulse to the granted receiver
out_valid  output  1  output byte valid
out_ready  input  1  downstream accepts the byte when out_valid&&out_ready
out_data  output  8  captured byte
out_lane  output  LANE_W  source lane index
out_error  output  2  bit0 = framing error, bit1 = overrun, captured with the byte
err_count  output  ERR_CNT_W  count of delivered bytes with out_error!=0, saturating
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, n_rst=0) values: lane_data_read=0, out_valid=0, out_data=0, out_lane=0, out_error=0, err_count=0, busy=0, rr_ptr=0, state=IDLE.
- eligible = lane_data_ready & lane_enable.
- out_free = !out_valid || out_ready.
- State IDLE:
  - Grant only if eligible!=0 and out_free.
  - Winner w = first eligible lane searching upward from rr_ptr, wrapping NUM_LANES-1 -> 0.
  - On that edge: out_data <= lane_rx_data[w], out_lane <= w, out_error <= {lane_overrun[w], lane_framing_error[w]}, out_valid <= 1, rr_ptr <= (w+1) mod NUM_LANES, state <= ACK.
  - If eligible!=0 but the output is not free: stay in IDLE, no grant.
- State ACK:
  - lane_data_read[w]=1 for exactly this one cycle; it is a registered output, all other bits 0.
  - Next edge: state <= SETTLE.
- State SETTLE:
  - One dead cycle so the receiver's data_ready falls; no grant.
  - Next edge: state <= IDLE.
- Latency and throughput: byte on out_data the cycle after grant. data_read asserted the cycle after grant. Maximum one grant per 3 cycles.
- Output register: out_valid clears on an out_ready handshake unless a new capture occurs on the same edge. Same-edge accept and new capture are legal; the new byte overwrites and out_valid stays 1. While out_valid=1 and out_ready=0, out_* hold stable.
- err_count increments by 1 on each accepted handshake with out_error!=0. It holds at all-ones, with no wrap.
- lane_enable deasserted during ACK/SETTLE: the handshake still completes for w. Disabled lanes keep their bytes pending and never get data_read.
- Single eligible lane: regranted every 3 cycles as long as data_ready reasserts.
- NUM_LANES lanes all eligible: grant order rr_ptr, rr_ptr+1, ... with wrap. No lane waits more than NUM_LANES grants.
- Reset mid-operation: any pending data_read pulse is cancelled and the captured byte is discarded.

Optional Feature:
Macro LANE_ARB_TIMESTAMP_EN.
- Defined:
  - Adds output out_timestamp [15:0], reset 0.
  - A free-running 16-bit cycle counter, reset 0, wraps FFFF->0000.
  - Its value is captured into out_timestamp on the grant edge and is stable while out_valid=1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: all inputs 0 -> all outputs 0, busy=0, no lane_data_read for 20 cycles.
- Single lane: lane 2 ready with 8'hA5, out_ready=1 -> out_valid=1, out_data=A5, out_lane=2 one cycle after grant. lane_data_read=8'b0000_0100 for exactly 1 cycle.
- Round robin fairness: lanes 0,3,5 ready simultaneously and re-asserted, rr_ptr=0 -> grant order 0,3,5,0,3,... with grants spaced 3 cycles apart.
- Backpressure: out_ready=0, lanes 1 and 4 ready -> lane 1 byte held stable with out_valid=1 and no further grant. out_ready=1 on cycle N -> lane 4 captured on the same edge.
- Errors/saturation: lane 6 delivers 3 bytes with framing_error=1 -> out_error=2'b01 each and err_count=3. Forcing err_count to FFFF then one more errored byte -> stays FFFF.
- Enable mask and reset: lane_enable=8'hFE, lane 0 ready -> never granted. Assert n_rst in ACK -> lane_data_read drops immediately and out_valid=0.

Source files
------------

// File: rtl/lane_byte_arbiter.sv
// Purpose : round-robin arbiter sharing one byte-wide output stream among NUM_LANES serial byte receivers.
// Latency : byte and lane_data_read appear the cycle after the grant; at most one grant every 3 cycles.
// Backpres: no grant while out_valid=1 and out_ready=0; the held byte stays stable. Optional LANE_ARB_TIMESTAMP_EN adds out_timestamp.
module lane_byte_arbiter #(
    parameter int NUM_LANES = 8,
    parameter int LANE_W    = 3,
    parameter int ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_LANES-1:0]   lane_enable,
    input  logic [NUM_LANES-1:0]   lane_data_ready,
    input  logic [NUM_LANES*8-1:0] lane_rx_data,
    input  logic [NUM_LANES-1:0]   lane_overrun,
    input  logic [NUM_LANES-1:0]   lane_framing_error,
    output logic [NUM_LANES-1:0]   lane_data_read,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [LANE_W-1:0]      out_lane,
    output logic [1:0]             out_error,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   busy
`ifdef LANE_ARB_TIMESTAMP_EN
    ,
    output logic [15:0]            out_timestamp
`endif
);

    // IDLE looks for a winner, ACK carries the data_read pulse, SETTLE lets the
    // receiver drop data_ready before the lanes are examined again.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Everything captured from the winning lane travels together.
    typedef struct packed {
        logic [7:0]        dat;
        logic [LANE_W-1:0] lane;
        logic [1:0]        err;
    } beat_t;

    state_t              state_q;
    state_t              state_d;
    logic [LANE_W-1:0]   rr_ptr;
    logic [NUM_LANES-1:0] eligible;
    logic                out_free;
    logic                win_vld;
    logic [LANE_W-1:0]   win_idx;
    logic [LANE_W-1:0]   cand;
    logic                grant;
    logic                accept;
    beat_t               win_beat;

    assign eligible = lane_data_ready & lane_enable;
    assign out_free = !out_valid || out_ready;
    assign accept   = out_valid && out_ready;
    assign busy     = (state_q != IDLE);

    // Search upward from rr_ptr; the LANE_W-bit add wraps because NUM_LANES is a power of two.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = rr_ptr + LANE_W'(i);
            if (!win_vld && eligible[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant only from IDLE, and only when the output register can take a new byte.
    assign grant = (state_q == IDLE) && win_vld && out_free;

    // Gather the winner's byte and flags; error bit1 = overrun, bit0 = framing.
    always_comb begin
        win_beat      = '0;
        win_beat.dat  = lane_rx_data[win_idx*8 +: 8];
        win_beat.lane = win_idx;
        win_beat.err  = {lane_overrun[win_idx], lane_framing_error[win_idx]};
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a grant always walks through ACK and SETTLE back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACK;
            ACK:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round-robin pointer moves just past the lane that won.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= win_idx + LANE_W'(1);
        end
    end

    // data_read is registered: set on the grant edge, so it is high only during ACK.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lane_data_read <= '0;
        end else if (grant) begin
            lane_data_read <= NUM_LANES'(1) << win_idx;
        end else begin
            lane_data_read <= '0;
        end
    end

    // Output register: a capture wins over a same-edge handshake, otherwise the handshake empties it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_error <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= win_beat.dat;
            out_lane  <= win_beat.lane;
            out_error <= win_beat.err;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

    // Count delivered errored bytes; stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_count <= '0;
        end else if (accept && (out_error != 2'b00) && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

`ifdef LANE_ARB_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end

    // Timestamp is taken with the byte and held until the next capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_timestamp <= '0;
        end else if (grant) begin
            out_timestamp <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_lane_byte_arbiter.sv
// Purpose : directed bench for lane_byte_arbiter with a small receiver model per lane.
// Latency : checks sampled 1 time unit after each rising edge.
// Backpres: exercises out_ready low holding the byte and same-edge accept plus capture.
module tb_lane_byte_arbiter;

    localparam int NL  = 8;
    localparam int LW  = 3;
    localparam int ECW = 3;
    localparam logic [ECW-1:0] ECMAX = '1;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [NL-1:0]   lane_enable;
    logic [NL-1:0]   lane_data_ready;
    logic [NL*8-1:0] lane_rx_data;
    logic [NL-1:0]   lane_overrun;
    logic [NL-1:0]   lane_framing_error;
    logic [NL-1:0]   lane_data_read;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [LW-1:0]   out_lane;
    logic [1:0]      out_error;
    logic [ECW-1:0]  err_count;
    logic            busy;
`ifdef LANE_ARB_TIMESTAMP_EN
    logic [15:0]     out_timestamp;
`endif

    lane_byte_arbiter #(.NUM_LANES(NL), .LANE_W(LW), .ERR_CNT_W(ECW)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .lane_enable        (lane_enable),
        .lane_data_ready    (lane_data_ready),
        .lane_rx_data       (lane_rx_data),
        .lane_overrun       (lane_overrun),
        .lane_framing_error (lane_framing_error),
        .lane_data_read     (lane_data_read),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_lane           (out_lane),
        .out_error          (out_error),
        .err_count          (err_count),
        .busy               (busy)
`ifdef LANE_ARB_TIMESTAMP_EN
        ,
        .out_timestamp      (out_timestamp)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Receiver model: rem = bytes still queued, rxb = byte currently presented.
    int         rem [NL];
    logic [7:0] rxb [NL];

    typedef struct {
        int         lane;
        logic [7:0] dat;
        logic       fe;
        logic       ov;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_rx();
        for (int i = 0; i < NL; i++) begin
            lane_data_ready[i]      = (rem[i] != 0);
            lane_rx_data[i*8 +: 8]  = rxb[i];
        end
    endtask

    // One clock: a receiver that saw data_read before the edge pops its byte.
    task automatic tick();
        logic [NL-1:0] dr;
        dr = lane_data_read;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NL; i++) begin
            if (dr[i] && rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                rxb[i] = rxb[i] + 8'd1;
            end
        end
        drive_rx();
    endtask

    // Tick until a data_read pulse shows up; returns the lane and cycle number.
    task automatic wait_grant(output int lane, output int at);
        int n;
        lane = -1;
        at   = -1;
        n    = 0;
        while (lane < 0 && n < 40) begin
            tick();
            n++;
            for (int i = 0; i < NL; i++) begin
                if (lane_data_read[i]) lane = i;
            end
        end
        at = cyc;
        if (lane < 0) chk("grant_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int g;
        int at;
        int prev_at;
        int bad;
        int ord [9];
        int seen [NL];
        logic [7:0] base [NL];
        logic [ECW-1:0] exp_cnt;

        n_rst              = 1'b0;
        lane_enable        = '0;
        lane_overrun       = '0;
        lane_framing_error = '0;
        out_ready          = 1'b0;
        for (int i = 0; i < NL; i++) begin
            rem[i]  = 0;
            rxb[i]  = 8'h00;
            seen[i] = 0;
            base[i] = 8'h00;
        end
        drive_rx();
        exp_cnt = '0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data_read", lane_data_read, 0);
        chk("rst_data", out_data, 0);
        chk("rst_lane", out_lane, 0);
        chk("rst_error", out_error, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_busy", busy, 0);

        // ---- idle with all inputs zero ----
        n_rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lane_data_read != 0 || busy || out_valid) bad++;
        end
        chk("idle_quiet", bad, 0);

        lane_enable = '1;
        out_ready   = 1'b1;

        // ---- table: single-lane grants with varied error flags ----
        vt[0] = '{lane: 2, dat: 8'hA5, fe: 1'b0, ov: 1'b0, exp_err: 2'b00};
        vt[1] = '{lane: 0, dat: 8'hFF, fe: 1'b0, ov: 1'b1, exp_err: 2'b10};
        vt[2] = '{lane: 5, dat: 8'h00, fe: 1'b1, ov: 1'b1, exp_err: 2'b11};
        vt[3] = '{lane: 7, dat: 8'h3C, fe: 1'b1, ov: 1'b0, exp_err: 2'b01};
        for (int v = 0; v < 4; v++) begin
            rxb[vt[v].lane]                = vt[v].dat;
            rem[vt[v].lane]                = 1;
            lane_framing_error[vt[v].lane] = vt[v].fe;
            lane_overrun[vt[v].lane]       = vt[v].ov;
            drive_rx();
            wait_grant(g, at);
            chk("tbl_grant_lane", g, vt[v].lane);
            chk("tbl_data_read", lane_data_read, 32'd1 << vt[v].lane);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data, vt[v].dat);
            chk("tbl_lane", out_lane, vt[v].lane);
            chk("tbl_error", out_error, vt[v].exp_err);
            chk("tbl_busy_ack", busy, 1);
            lane_framing_error = '0;
            lane_overrun       = '0;
            tick();
            chk("tbl_read_one_cycle", lane_data_read, 0);
            chk("tbl_busy_settle", busy, 1);
            chk("tbl_drained", out_valid, 0);
            if (vt[v].exp_err != 2'b00 && exp_cnt != ECMAX) exp_cnt = exp_cnt + 1'b1;
            tick();
            chk("tbl_err_count", err_count, exp_cnt);
            chk("tbl_idle", busy, 0);
        end

        // ---- round robin: lanes 0,3,5 each with three bytes, rr_ptr now 0 ----
        base[0] = 8'h10; base[3] = 8'h30; base[5] = 8'h50;
        rxb[0] = base[0]; rxb[3] = base[3]; rxb[5] = base[5];
        rem[0] = 3; rem[3] = 3; rem[5] = 3;
        drive_rx();
        ord = '{0, 3, 5, 0, 3, 5, 0, 3, 5};
        prev_at = 0;
        for (int k = 0; k < 9; k++) begin
            wait_grant(g, at);
            chk("rr_order", g, ord[k]);
            chk("rr_data", out_data, base[ord[k]] + 8'(seen[ord[k]]));
            if (k > 0) chk("rr_spacing", at - prev_at, 3);
            seen[ord[k]]++;
            prev_at = at;
        end
        repeat (4) tick();
        chk("rr_drained", out_valid, 0);

        // ---- backpressure: lanes 1 and 4, rr_ptr now 6 ----
        out_ready = 1'b0;
        rxb[1] = 8'h11; rem[1] = 1;
        rxb[4] = 8'h44; rem[4] = 1;
        drive_rx();
        wait_grant(g, at);
        chk("bp_first_lane", g, 1);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!out_valid || out_data != 8'h11 || out_lane != 3'd1 || lane_data_read != 0) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        chk("bp_parked_idle", busy, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_same_edge_read", lane_data_read, 8'b0001_0000);
        chk("bp_same_edge_valid", out_valid, 1);
        chk("bp_same_edge_data", out_data, 8'h44);
        chk("bp_same_edge_lane", out_lane, 4);
        repeat (3) tick();
        chk("bp_drained", out_valid, 0);

        // ---- enable mask, then reset during ACK; rr_ptr now 5 ----
        lane_enable = 8'hFE;
        rxb[0] = 8'h99; rem[0] = 1;
        drive_rx();
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (lane_data_read != 0 || out_valid) bad++;
        end
        chk("mask_never_granted", bad, 0);
        rxb[2] = 8'h22; rem[2] = 1;
        drive_rx();
        wait_grant(g, at);
        chk("mask_skip_to_lane2", g, 2);
        chk("mask_valid", out_valid, 1);
        n_rst = 1'b0;
        #1;
        chk("arst_data_read", lane_data_read, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", out_data, 0);
        for (int i = 0; i < NL; i++) rem[i] = 0;
        drive_rx();
        @(posedge clk);
        #1;
        n_rst       = 1'b1;
        lane_enable = '1;
        exp_cnt     = '0;

        // ---- framing errors on lane 6 and counter saturation ----
        lane_framing_error[6] = 1'b1;
        rxb[6] = 8'h60; rem[6] = 9;
        drive_rx();
        for (int k = 0; k < 9; k++) begin
            wait_grant(g, at);
            chk("err_lane", g, 6);
            chk("err_flags", out_error, 2'b01);
            tick();
            if (exp_cnt != ECMAX) exp_cnt = exp_cnt + 1'b1;
            chk("err_count", err_count, exp_cnt);
        end
        repeat (3) tick();
        chk("err_count_saturated", err_count, ECMAX);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
